// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush with saturating drop accounting, and a bubble payload when empty.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W     = 96,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(32'h13),
    parameter bit                SKID_EN    = 1'b1,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [CNT_W:0]      drop_sum;
    logic                main_valid;
    logic                skid_valid;
    logic                acc;
    logic                emit;

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == TWO);

    // Handshake: skid mode keeps in_ready off the out_ready path.
    assign out_valid_o = main_valid & ~stall_i & ~flush_i;
    assign in_ready_o  = (SKID_EN ? ~skid_valid : (~main_valid | out_ready_i))
                         & ~stall_i & ~flush_i;
    assign acc         = in_valid_i & in_ready_o;
    assign emit        = out_valid_o & out_ready_i;

    assign out_data_o  = main_valid ? main_q : BUBBLE_VAL;
    assign occupancy_o = state_q;
    assign drop_cnt_o  = drop_q;

    // Drop counter increment by current occupancy, saturating at all-ones.
    assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(state_q);

    // Next-state and datapath: flush overrides; stall implies no acc/emit so contents hold.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        drop_d  = drop_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
            drop_d  = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data_i;
                    end
                end
                ONE: begin
                    if (acc && emit) begin
                        main_d = in_data_i;
                    end else if (acc && SKID_EN) begin
                        state_d = TWO;
                        skid_d  = in_data_i;
                    end else if (emit) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                TWO: begin
                    if (emit) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // State, payload and counter registers; reset drops contents without counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            drop_q  <= drop_d;
        end
    end

endmodule
